// File: rtl/sort_pkg.sv
// Shared types and defaults for the bubble sort controller.
// State encoding, default geometry and swap counter width.
package sort_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_UNLOAD
  } sort_state_e;

  localparam int SORT_WIDTH = 3;
  localparam int SORT_DEPTH = 4;
  localparam int SWAP_CNT_W = 8;

endpackage

// File: rtl/mag_cmp.sv
// Combinational unsigned magnitude comparator.
// Shared by every compare-and-swap step of the sorter.
module mag_cmp #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  assign a_lt_b = a_i < b_i;
  assign a_gt_b = a_i > b_i;
  assign a_eq_b = a_i == b_i;

endmodule

// File: rtl/bubble_sort_controller.sv
// In-place bubble sort of a DEPTH-word block, one compare per cycle.
// Words stream in, get sorted ascending, then stream out smallest first.
module bubble_sort_controller
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int DEPTH = SORT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [SWAP_CNT_W-1:0] swap_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] J_LAST = PW'(DEPTH - 2);

  sort_state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] j_q, j_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [SWAP_CNT_W-1:0] cnt_q, cnt_d;
  logic [SWAP_CNT_W-1:0] swc_q, swc_d;
  logic psw_q, psw_d;

  logic [PW-1:0] jn;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic gt, cmp_lt_unused, cmp_eq_unused;
  logic in_fire, out_fire;
  logic load_done, pass_end, sort_done, unload_done;

  assign jn    = j_q + PW'(1);
  assign cmp_a = mem_q[j_q];
  assign cmp_b = mem_q[jn];

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i   (cmp_a),
    .b_i   (cmp_b),
    .a_lt_b(cmp_lt_unused),
    .a_gt_b(gt),
    .a_eq_b(cmp_eq_unused)
  );

  assign in_fire     = (state_q == S_LOAD) && in_valid;
  assign out_fire    = (state_q == S_UNLOAD) && out_ready;
  assign load_done   = in_fire && (wr_q == PTR_LAST);
  assign pass_end    = j_q == (J_LAST - pass_q);
  // Early exit once a whole pass has run without a single swap.
  assign sort_done   = pass_end &&
                       ((pass_q == J_LAST) || !(psw_q || gt));
  assign unload_done = out_fire && (rd_q == PTR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (load_done)   state_d = S_SORT;
      S_SORT:   if (sort_done)   state_d = S_UNLOAD;
      S_UNLOAD: if (unload_done) state_d = S_LOAD;
      default:                   state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready   = state_q == S_LOAD;
    busy       = state_q == S_SORT;
    out_valid  = state_q == S_UNLOAD;
    out_data   = out_valid ? mem_q[rd_q] : '0;
    out_last   = out_valid && (rd_q == PTR_LAST);
    swap_count = swc_q;
  end

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    j_d    = j_q;
    pass_d = pass_q;
    cnt_d  = cnt_q;
    swc_d  = swc_q;
    psw_d  = psw_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          mem_d[wr_q] = in_data;
          wr_d = wr_q + PW'(1);
        end
        if (load_done) begin
          wr_d   = '0;
          j_d    = '0;
          pass_d = '0;
          cnt_d  = '0;
          psw_d  = 1'b0;
        end
      end
      S_SORT: begin
        if (gt) begin
          mem_d[j_q] = cmp_b;
          mem_d[jn]  = cmp_a;
          cnt_d = cnt_q + SWAP_CNT_W'(1);
        end
        if (pass_end) begin
          j_d    = '0;
          pass_d = pass_q + PW'(1);
          psw_d  = 1'b0;
        end else begin
          j_d   = jn;
          psw_d = psw_q || gt;
        end
        if (sort_done) swc_d = cnt_q + SWAP_CNT_W'(gt);
      end
      S_UNLOAD: begin
        if (out_fire) rd_d = unload_done ? '0 : rd_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      j_q    <= '0;
      pass_q <= '0;
      cnt_q  <= '0;
      swc_q  <= '0;
      psw_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      j_q    <= j_d;
      pass_q <= pass_d;
      cnt_q  <= cnt_d;
      swc_q  <= swc_d;
      psw_q  <= psw_d;
    end
  end

endmodule

// File: tb/tb_bubble_sort_controller.sv
// Bench for bubble_sort_controller: directed and random blocks
// checked against a sorted-order / inversion-count reference.
module tb_bubble_sort_controller;

  localparam int W = 3;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic out_last;
  logic busy;
  logic [7:0] swap_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bubble_sort_controller #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .swap_count(swap_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sorted order by stable rank, swaps = inversion count, and
  // passes = one more than the largest per-element left inversion count
  // (the extra pass confirms order), capped at D-1 passes.
  function automatic void model(input logic [W-1:0] v [D],
                                output logic [W-1:0] s [D],
                                output int swaps, output int cyc);
    int k, kmax, r, p;
    swaps = 0;
    kmax = 0;
    for (int i = 0; i < D; i++) begin
      k = 0;
      r = 0;
      for (int j = 0; j < D; j++) begin
        if (j < i && v[j] > v[i]) k++;
        if (v[j] < v[i] || (v[j] == v[i] && j < i)) r++;
      end
      swaps += k;
      if (k > kmax) kmax = k;
      s[r] = v[i];
    end
    p = (kmax + 1 < D - 1) ? kmax + 1 : D - 1;
    cyc = 0;
    for (int q = 0; q < p; q++) cyc += D - 1 - q;
  endfunction

  task automatic load_words(input logic [W-1:0] v [D], input bit rnd);
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      while (rnd && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data = W'($urandom);
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = v[i];
      chk("in_ready_load", in_ready, 1);
      @(negedge clk);
    end
  endtask

  task automatic run_block(input logic [W-1:0] v [D], input bit rnd,
                           input int st_at, input int st_len);
    logic [W-1:0] s [D];
    int swaps, cyc, n, got, stalled, t;
    model(v, s, swaps, cyc);
    load_words(v, rnd);
    in_data = W'($urandom);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 0) begin
        chk("in_ready_sort", in_ready, 0);
        chk("out_valid_sort", out_valid, 0);
      end
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, cyc);
    chk("swap_count", swap_count, swaps);
    got = 0;
    stalled = 0;
    t = 0;
    while (got < D && t < 400) begin
      t++;
      if (got == st_at && stalled < st_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      in_data = W'($urandom);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, s[got]);
      chk("out_last", out_last, 32'(got == D - 1));
      @(negedge clk);
      if (out_ready) got++;
    end
    in_valid = 1'b0;
    chk("unload_words", got, D);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] v [D];
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_count", swap_count, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    v = '{3'd4, 3'd2, 3'd6, 3'd7};
    run_block(v, 1'b0, -1, 0);
    chk("sc1_swaps", swap_count, 1);
    v = '{3'd1, 3'd2, 3'd3, 3'd4};
    run_block(v, 1'b0, -1, 0);
    v = '{3'd7, 3'd5, 3'd3, 3'd0};
    run_block(v, 1'b0, -1, 0);
    chk("sc3_swaps", swap_count, 6);
    v = '{3'd2, 3'd2, 3'd1, 3'd2};
    run_block(v, 1'b0, -1, 0);
    v = '{3'd4, 3'd2, 3'd6, 3'd7};
    run_block(v, 1'b0, 2, 3);

    v = '{3'd7, 3'd5, 3'd3, 3'd0};
    load_words(v, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_swap_count", swap_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    v = '{3'd3, 3'd1, 3'd2, 3'd0};
    run_block(v, 1'b0, -1, 0);

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < D; i++) v[i] = W'($urandom_range(0, 7));
      run_block(v, 1'b1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bubble_sort_controller.md
Name: bubble_sort_controller

Overview:
Sequencer that shares one combinational magnitude comparator to sort a small block of DEPTH unsigned WIDTH-bit words in ascending order.
- Words are streamed in over a valid/ready interface and sorted in place with a bubble sort at one compare-and-swap per cycle.
- Sorted words are then streamed out over a valid/ready interface.
- Sits between a data producer and consumer as a reusable sort/rank stage.

Parameters:
WIDTH, 3, data word width in bits
DEPTH, 4, words per block; legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller accepts a word this cycle
in_data  input  WIDTH  unsigned input word
out_valid  output  1  out_data holds a sorted word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  sorted word, smallest first
out_last  output  1  high with the final (DEPTH-th) output word
busy  output  1  high while in SORT state
swap_count  output  8  number of swaps performed in the most recent sort

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n is low:
  - state = LOAD; all storage words = 0; load, pass, index and unload counters = 0.
  - in_ready = 1; out_valid = 0; out_last = 0; busy = 0; swap_count = 0; out_data = 0.
- Reset asserted mid-operation (any state) aborts the block immediately. No partial output is produced afterwards.
- States: LOAD -> SORT -> UNLOAD -> LOAD.
- LOAD:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready writes in_data to mem[wr_ptr] and increments wr_ptr.
  - The DEPTH-th accept moves to SORT next cycle. wr_ptr, pass and j clear; per-sort swap counter clears.
- SORT:
  - busy = 1; in_ready = 0; out_valid = 0.
  - Each cycle compares mem[j] (A) with mem[j+1] (B).
  - If A > B, the two entries are swapped and the swap counter increments. Equal values are never swapped, so the sort is stable.
  - j runs 0..DEPTH-2-pass. At the end of a pass, pass increments and j resets to 0.
  - The sort ends after the last compare of pass DEPTH-2, or at the end of any pass with zero swaps (early exit).
  - On exit: swap_count is loaded with the final count, and the state goes to UNLOAD next cycle.
  - Cycle counts: best case DEPTH-1 compare cycles; worst case DEPTH*(DEPTH-1)/2.
- UNLOAD:
  - out_valid = 1; out_data = mem[rd_ptr]; out_last = (rd_ptr == DEPTH-1).
  - On out_valid & out_ready, rd_ptr increments.
  - While out_ready is low, out_data and out_last are held stable and no word is skipped.
  - The transfer with out_last moves to LOAD next cycle. rd_ptr clears; in_ready = 1 in that cycle.
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.
- The block never overlaps load and unload: no simultaneous in/out transfers.
- swap_count holds its value until the next sort exits or reset. The maximum for DEPTH = 16 is 120, which fits in 8 bits.
- Arithmetic: compares are unsigned over WIDTH bits. Pointers are $clog2(DEPTH) bits and wrap only via explicit clear.

Decomposition:
- Shared package sort_pkg:
  - state enum: S_LOAD, S_SORT, S_UNLOAD.
  - default WIDTH and DEPTH constants.
  - SWAP_CNT_W = 8.
- One sub-module, mag_cmp:
  - combinational, parameterised by WIDTH.
  - outputs a_lt_b, a_gt_b, a_eq_b.
  - instantiated once; only a_gt_b drives the swap decision.

Test Plan:
1. WIDTH=3, DEPTH=4. Load 4,2,6,7 -> busy high 5 cycles; unload 2,4,6,7; out_last on 7; swap_count = 1.
2. Load 1,2,3,4 (already sorted) -> busy high 3 cycles (early exit after pass 0); unload 1,2,3,4; swap_count = 0.
3. Load 7,5,3,0 (reverse order) -> busy high 6 cycles; unload 0,3,5,7; swap_count = 6.
4. Load 2,2,1,2 (duplicates) -> busy high 6 cycles; unload 1,2,2,2; swap_count = 2; equal entries never swapped.
5. Backpressure: in scenario 1, drop out_ready for 3 cycles after the second word -> out_valid stays 1 with out_data = 6 stable; the full sequence 2,4,6,7 is delivered with no loss or duplication.
6. Reset mid-operation: assert rst_n low during SORT of scenario 3 -> immediately busy = 0, out_valid = 0, swap_count = 0. After release, in_ready = 1, and a fresh load of 3,1,2,0 unloads 0,1,2,3.
